// File: rtl/bitboard_iter.sv
// bitboard_iter: turns a WIDTH-square bitboard into a stream of square beats, lowest square
// first. Each beat carries the isolated one-hot square, its binary index and the sideband tag.
// Valid/ready handshake on both sides; a new bitboard may be taken on the final beat of the
// current one, so consecutive non-empty bitboards stream with no bubbles.
// Optional feature: define BITBOARD_ITER_EMPTY_EN so that a zero bitboard produces one marker
// beat with out_empty_o set. Without it, a zero bitboard is consumed silently and out_empty_o
// is tied low.
module bitboard_iter #(
  parameter int unsigned WIDTH       = 64,
  parameter int unsigned TAG_WIDTH   = 6,
  localparam int unsigned INDEX_WIDTH = $clog2(WIDTH)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic [WIDTH-1:0]       in_bits_i,
  input  logic [TAG_WIDTH-1:0]   in_tag_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [WIDTH-1:0]       out_onehot_o,
  output logic [INDEX_WIDTH-1:0] out_index_o,
  output logic [TAG_WIDTH-1:0]   out_tag_o,
  output logic                   out_last_o,
  output logic                   out_empty_o
);

  localparam logic [WIDTH-1:0] One = WIDTH'(1);

  typedef enum logic [1:0] {StIdle, StIter, StEmpty} state_e;

  state_e                 state_q, state_d;
  logic [WIDTH-1:0]       rem_q, rem_d;
  logic [TAG_WIDTH-1:0]   tag_q, tag_d;

  logic [WIDTH-1:0]       lowest;
  logic [WIDTH-1:0]       rem_rest;
  logic                   empty_beat;
  logic                   accept;
  logic                   fire;

  // Lowest set square, and what remains once it has been sent.
  assign lowest   = rem_q & (~rem_q + One);
  assign rem_rest = rem_q & (rem_q - One);

  assign out_tag_o = tag_q;

  // Beat presentation and input readiness, decoded from the current state.
  always_comb begin
    in_ready_o   = 1'b0;
    out_valid_o  = 1'b0;
    out_onehot_o = '0;
    out_last_o   = 1'b0;
    empty_beat   = 1'b0;
    unique case (state_q)
      StIdle: begin
        in_ready_o = 1'b1;
      end
      StIter: begin
        out_valid_o  = 1'b1;
        out_onehot_o = lowest;
        out_last_o   = (rem_rest == '0);
        // Taking the next bitboard on the final beat keeps the stream bubble-free.
        in_ready_o   = out_last_o & out_ready_i;
      end
`ifdef BITBOARD_ITER_EMPTY_EN
      StEmpty: begin
        out_valid_o = 1'b1;
        out_last_o  = 1'b1;
        empty_beat  = 1'b1;
        in_ready_o  = out_ready_i;
      end
`endif
      default: ;
    endcase
    if (rst_i) in_ready_o = 1'b0;
  end

`ifdef BITBOARD_ITER_EMPTY_EN
  assign out_empty_o = empty_beat;
`else
  assign out_empty_o = 1'b0;
  logic unused_empty;
  assign unused_empty = empty_beat;
`endif

  // Binary index of the isolated square: OR of the positions of all set one-hot bits.
  always_comb begin
    out_index_o = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (out_onehot_o[i]) out_index_o = out_index_o | INDEX_WIDTH'(i);
    end
  end

  // Next state: retire the sent square, then let a same-cycle accept override.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    tag_d   = tag_q;
    accept  = in_valid_i & in_ready_o;
    fire    = out_valid_o & out_ready_i;

    if (fire) begin
      rem_d = rem_rest;
      if (out_last_o) state_d = StIdle;
    end

    if (accept) begin
      rem_d = in_bits_i;
      if (in_bits_i != '0) begin
        tag_d   = in_tag_i;
        state_d = StIter;
      end else begin
`ifdef BITBOARD_ITER_EMPTY_EN
        tag_d   = in_tag_i;
        state_d = StEmpty;
`else
        state_d = StIdle;
`endif
      end
    end
  end

  // State registers with synchronous reset; reset discards any remaining squares.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      rem_q   <= '0;
      tag_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      tag_q   <= tag_d;
    end
  end

endmodule
